idwt_upsample_ctrl: RTL and testbench
=====================================

# idwt_upsample_ctrl

Sequencing controller for the inverse-wavelet upsampling stage of the ECG reconstruction path. It fetches coefficient pairs (g detail, f approximation) from the coefficient buffer over a valid/ready handshake and emits each pair as two output slots, even then odd, for the synthesis filters. It walks a fixed number of decomposition levels, each level twice as long as the one before, and reports level and frame completion. It sits between the coefficient buffer and the synthesis filter bank.

## Interface
- DATA_W, 16, coefficient width (signed)
- LEVELS, 4, number of reconstruction levels (>=1)
- FRAME_LEN, 256, output samples of the final level; power of two, >= 2^LEVELS
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- clk_enable  input  1  when low, all registers hold
- start  input  1  begin a frame; honoured only in IDLE
- in_valid  input  1  coefficient pair available
- in_ready  output  1  controller accepts a pair; equals (state==FETCH)
- g_in, f_in  input  DATA_W  signed coefficient pair
- out_ready  input  1  filter bank accepts a slot
- out_valid  output  1  output slot valid
- g_out, f_out  output  DATA_W  signed upsampled samples
- out_phase  output  1  0 for the even (coefficient) slot, 1 for the odd slot
- out_level  output  max(1,$clog2(LEVELS))  current level index
- out_last  output  1  final odd slot of the current level
- level_done  output  1  one-cycle pulse after a level's last slot is accepted
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse at frame end

## Operation
- PAIRS(k) = FRAME_LEN >> (LEVELS-k) for level k = 0..LEVELS-1. With the defaults: 16, 32, 64, 128 pairs; 240 pairs per frame.
- FSM states: IDLE, FETCH, EVEN, ODD, DONE.
- IDLE: if start, then level=0, cnt=0, go to FETCH.
- FETCH: in_ready=1. On in_valid, capture g_in/f_in into hold registers and go to EVEN.
- EVEN: out_valid=1, out_phase=0, g_out/f_out = held pair. On out_ready, go to ODD.
- ODD: out_valid=1, out_phase=1, odd-slot data (see Configuration). out_last=1 when cnt==PAIRS(level)-1. On out_ready:
  - If not the last pair: cnt++, go to FETCH.
  - If the last pair and level<LEVELS-1: level++, cnt=0, pulse level_done, go to FETCH.
  - If the last pair and level==LEVELS-1: pulse level_done, go to DONE.
- DONE: done=1 for one enabled cycle, then go to IDLE.
- Held data is stable while out_valid=1 and out_ready=0.
- A start outside IDLE is ignored.
- Arithmetic: pure data routing, no scaling or truncation. cnt width is $clog2(FRAME_LEN). Compare against PAIRS(level) computed from parameters.

## Timing
- Reset (async, any state, including mid-frame): state=IDLE, level=0, cnt=0. All outputs are 0: in_ready, out_valid, g_out, f_out, out_phase, out_level, out_last, level_done, busy, done. Held pair is cleared.
- All outputs except in_ready are registered. in_ready is decoded from state.
- Fetch handshake in cycle N: even slot valid at N+1.
- Minimum throughput: 3 cycles per pair (FETCH, EVEN, ODD) with in_valid and out_ready held high.
- Frame latency at full rate: start, 1 cycle to FETCH, 3×240 cycles, DONE, IDLE. done is high 722 cycles after start sampled, with default parameters.
- clk_enable low: state, outputs and pulses freeze. A pulse stays high until the next enabled cycle ends.
- level_done and done never coincide. level_done appears in the cycle after the final ODD accept, and done one cycle later.

## Configuration
- UPSAMPLE_HOLD_EN undefined (default): true zero insertion. Odd slot g_out=f_out=0.
- UPSAMPLE_HOLD_EN defined: sample-and-hold. Odd slot repeats the held g/f pair.
- FSM and timing are identical in both builds.

## Test plan
- Reset during level 2 ODD slot, then release: all outputs 0, busy=0. A new start restarts at level 0, cnt 0.
- Defaults, in_valid=1, out_ready=1, g_in=n, f_in=-n for pair n:
  - Exactly 480 slots, alternating phase.
  - Even slots g_out=n, f_out=-n; odd slots 0.
  - level_done pulses after pairs 16, 48, 112 and 240; done at cycle 722.
- out_ready toggled randomly per cycle: data and phase stay stable while stalled. No slot is lost or duplicated; the total is still 480.
- in_valid low for 10 cycles in FETCH: in_ready stays 1, out_valid=0. Resumes correctly on the next valid.
- start pulsed while busy: ignored, frame count unchanged. clk_enable low for 5 cycles mid-EVEN: outputs frozen, then resume.
- With UPSAMPLE_HOLD_EN defined and g_in=0x1234: odd slot g_out=0x1234.

Source files
------------

// File: rtl/idwt_upsample_ctrl_if.sv
// Handshake bundle between the coefficient buffer, the upsampling controller
// and the synthesis filter bank. The controller side uses the master modport.
interface idwt_upsample_ctrl_if #(
    parameter int DATA_W = 16,
    parameter int LEVELS = 4
);
    localparam int LVL_W = (LEVELS > 1) ? $clog2(LEVELS) : 1;

    // coefficient buffer side
    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] g_in;
    logic signed [DATA_W-1:0] f_in;

    // synthesis filter side
    logic                     out_ready;
    logic                     out_valid;
    logic signed [DATA_W-1:0] g_out;
    logic signed [DATA_W-1:0] f_out;
    logic                     out_phase;
    logic [LVL_W-1:0]         out_level;
    logic                     out_last;

    modport master (
        input  in_valid,
        input  g_in,
        input  f_in,
        input  out_ready,
        output in_ready,
        output out_valid,
        output g_out,
        output f_out,
        output out_phase,
        output out_level,
        output out_last
    );

    modport slave (
        output in_valid,
        output g_in,
        output f_in,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  g_out,
        input  f_out,
        input  out_phase,
        input  out_level,
        input  out_last
    );
endinterface

// File: rtl/idwt_upsample_ctrl.sv
// Inverse-DWT upsampling sequencer: each fetched (g,f) pair becomes an even and
// an odd output slot. UPSAMPLE_HOLD_EN selects sample-and-hold odd slots.
module idwt_upsample_ctrl #(
    parameter int DATA_W    = 16,
    parameter int LEVELS    = 4,
    parameter int FRAME_LEN = 256
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clk_enable,
    input  logic                  start,
    idwt_upsample_ctrl_if.master  bus,
    output logic                  level_done,
    output logic                  busy,
    output logic                  done
);
    localparam int LVL_W = (LEVELS > 1) ? $clog2(LEVELS) : 1;
    localparam int CNT_W = $clog2(FRAME_LEN);
    localparam int LUT_N = 2 ** LVL_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EVEN,
        S_ODD,
        S_DONE
    } state_t;

    state_t                   state_reg, state_next;
    logic [LVL_W-1:0]         level_reg, level_next;
    logic [CNT_W-1:0]         cnt_reg, cnt_next;
    logic signed [DATA_W-1:0] g_hold_reg, g_hold_next;
    logic signed [DATA_W-1:0] f_hold_reg, f_hold_next;

    logic                     out_valid_reg, out_valid_next;
    logic signed [DATA_W-1:0] g_out_reg, g_out_next;
    logic signed [DATA_W-1:0] f_out_reg, f_out_next;
    logic                     out_phase_reg, out_phase_next;
    logic [LVL_W-1:0]         out_level_reg, out_level_next;
    logic                     out_last_reg, out_last_next;
    logic                     level_done_reg, level_done_next;
    logic                     busy_reg, busy_next;
    logic                     done_reg, done_next;

    logic                     fetch_fire;
    logic                     pair_is_last;
    logic                     level_is_final;

    // Last pair index of every level; entries past LEVELS-1 are never addressed.
    logic [CNT_W-1:0] last_idx [LUT_N];

    generate
        for (genvar gi = 0; gi < LUT_N; gi++) begin : g_last_idx
            if (gi < LEVELS) begin : g_used
                assign last_idx[gi] = CNT_W'((FRAME_LEN >> (LEVELS - gi)) - 1);
            end else begin : g_unused
                assign last_idx[gi] = '0;
            end
        end
    endgenerate

    assign fetch_fire     = (state_reg == S_FETCH) && bus.in_valid;
    assign pair_is_last   = (cnt_reg == last_idx[level_reg]);
    assign level_is_final = (level_reg == LVL_W'(LEVELS - 1));

    // Sequencing: which slot comes next and where in the frame we are.
    always_comb begin
        state_next      = state_reg;
        level_next      = level_reg;
        cnt_next        = cnt_reg;
        level_done_next = 1'b0;
        done_next       = 1'b0;

        unique case (state_reg)
            S_IDLE: begin
                if (start) begin
                    level_next = '0;
                    cnt_next   = '0;
                    state_next = S_FETCH;
                end
            end
            S_FETCH: begin
                if (bus.in_valid) begin
                    state_next = S_EVEN;
                end
            end
            S_EVEN: begin
                if (bus.out_ready) begin
                    state_next = S_ODD;
                end
            end
            S_ODD: begin
                if (bus.out_ready) begin
                    if (!pair_is_last) begin
                        cnt_next   = cnt_reg + CNT_W'(1);
                        state_next = S_FETCH;
                    end else begin
                        level_done_next = 1'b1;
                        if (level_is_final) begin
                            state_next = S_DONE;
                        end else begin
                            level_next = level_reg + LVL_W'(1);
                            cnt_next   = '0;
                            state_next = S_FETCH;
                        end
                    end
                end
            end
            S_DONE: begin
                done_next  = 1'b1;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Output slot contents are decoded from the upcoming state so every
    // output except in_ready leaves a register.
    always_comb begin
        g_hold_next    = fetch_fire ? bus.g_in : g_hold_reg;
        f_hold_next    = fetch_fire ? bus.f_in : f_hold_reg;
        out_valid_next = (state_next == S_EVEN) || (state_next == S_ODD);
        out_phase_next = (state_next == S_ODD);
        out_level_next = level_next;
        out_last_next  = (state_next == S_ODD) && (cnt_next == last_idx[level_next]);
        busy_next      = (state_next != S_IDLE);
        g_out_next     = '0;
        f_out_next     = '0;

        unique case (state_next)
            S_EVEN: begin
                g_out_next = g_hold_next;
                f_out_next = f_hold_next;
            end
            S_ODD: begin
`ifdef UPSAMPLE_HOLD_EN
                g_out_next = g_hold_next;
                f_out_next = f_hold_next;
`else
                g_out_next = '0;
                f_out_next = '0;
`endif
            end
            default: begin
                g_out_next = '0;
                f_out_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= S_IDLE;
            level_reg      <= '0;
            cnt_reg        <= '0;
            g_hold_reg     <= '0;
            f_hold_reg     <= '0;
            out_valid_reg  <= 1'b0;
            g_out_reg      <= '0;
            f_out_reg      <= '0;
            out_phase_reg  <= 1'b0;
            out_level_reg  <= '0;
            out_last_reg   <= 1'b0;
            level_done_reg <= 1'b0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
        end else if (clk_enable) begin
            state_reg      <= state_next;
            level_reg      <= level_next;
            cnt_reg        <= cnt_next;
            g_hold_reg     <= g_hold_next;
            f_hold_reg     <= f_hold_next;
            out_valid_reg  <= out_valid_next;
            g_out_reg      <= g_out_next;
            f_out_reg      <= f_out_next;
            out_phase_reg  <= out_phase_next;
            out_level_reg  <= out_level_next;
            out_last_reg   <= out_last_next;
            level_done_reg <= level_done_next;
            busy_reg       <= busy_next;
            done_reg       <= done_next;
        end
    end

    assign bus.in_ready  = (state_reg == S_FETCH);
    assign bus.out_valid = out_valid_reg;
    assign bus.g_out     = g_out_reg;
    assign bus.f_out     = f_out_reg;
    assign bus.out_phase = out_phase_reg;
    assign bus.out_level = out_level_reg;
    assign bus.out_last  = out_last_reg;
    assign level_done    = level_done_reg;
    assign busy          = busy_reg;
    assign done          = done_reg;
endmodule

// File: tb/tb_idwt_upsample_ctrl.sv
// Self-checking bench for idwt_upsample_ctrl: a slot-queue reference model
// built from the level/pair arithmetic, driven by randomized handshakes.
module tb_idwt_upsample_ctrl;
    localparam int DATA_W    = 16;
    localparam int LEVELS    = 4;
    localparam int FRAME_LEN = 256;
    localparam int LVL_W     = (LEVELS > 1) ? $clog2(LEVELS) : 1;
    localparam int SLOT_W    = 2 * DATA_W + LVL_W + 2;

    typedef struct {
        logic [SLOT_W-1:0] bits;
        bit                fin;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic clk_enable = 1'b0;
    logic start = 1'b0;
    logic level_done, busy, done;

    idwt_upsample_ctrl_if #(.DATA_W(DATA_W), .LEVELS(LEVELS)) bus ();

    idwt_upsample_ctrl #(
        .DATA_W   (DATA_W),
        .LEVELS   (LEVELS),
        .FRAME_LEN(FRAME_LEN)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .clk_enable(clk_enable),
        .start     (start),
        .bus       (bus),
        .level_done(level_done),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    int   total = 0, passed = 0, failed = 0;
    exp_t expq[$];
    bit   exp_ld = 0, ld_fin = 0, exp_done = 0, model_busy = 0, prev_stalled = 0;
    logic [SLOT_W-1:0] prev_obs = '0;
    int   p = 0, slots = 0, frames = 0, ld_count = 0;
    int   cyc = 0, start_cyc = 0, done_cyc = 0, mode = 0;

    function automatic int pairs_of(int k);
        return FRAME_LEN >> (LEVELS - k);
    endfunction

    function automatic int frame_pairs();
        int s = 0;
        for (int k = 0; k < LEVELS; k++) s += pairs_of(k);
        return s;
    endfunction

    function automatic int level_of(int n);
        int acc = 0;
        for (int k = 0; k < LEVELS; k++) begin
            acc += pairs_of(k);
            if (n < acc) return k;
        end
        return LEVELS - 1;
    endfunction

    function automatic bit last_of(int n);
        int acc = 0;
        for (int k = 0; k < LEVELS; k++) begin
            acc += pairs_of(k);
            if (n < acc) return (n == acc - 1);
        end
        return 1'b0;
    endfunction

    task automatic check(input string tag, input logic [63:0] o, input logic [63:0] e);
        total++;
        assert (o === e) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, o, e);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"},   64'(bus.in_ready),  64'(0));
        check({tag, "_out_valid"},  64'(bus.out_valid), 64'(0));
        check({tag, "_g_out"},      64'(bus.g_out),     64'(0));
        check({tag, "_f_out"},      64'(bus.f_out),     64'(0));
        check({tag, "_out_phase"},  64'(bus.out_phase), 64'(0));
        check({tag, "_out_level"},  64'(bus.out_level), 64'(0));
        check({tag, "_out_last"},   64'(bus.out_last),  64'(0));
        check({tag, "_level_done"}, 64'(level_done),    64'(0));
        check({tag, "_busy"},       64'(busy),          64'(0));
        check({tag, "_done"},       64'(done),          64'(0));
    endtask

    task automatic model_clear();
        expq.delete();
        exp_ld = 0; ld_fin = 0; exp_done = 0; model_busy = 0;
        prev_stalled = 0; p = 0;
    endtask

    // One clock: check this cycle's outputs, drive inputs, advance the model.
    task automatic cycle(input bit st, input bit rdy, input bit vld, input bit en);
        logic [SLOT_W-1:0] obs;
        logic [DATA_W-1:0] gv, fv;
        bit   out_fire, in_fire, start_acc, ld_new, fin_new;
        int   lvl;
        exp_t e, e_even, e_odd;
        @(negedge clk);
        cyc++;
        obs = {bus.g_out, bus.f_out, bus.out_phase, bus.out_level, bus.out_last};
        check("busy", 64'(busy), 64'(model_busy));
        check("level_done", 64'(level_done), 64'(exp_ld));
        check("done", 64'(done), 64'(exp_done));
        if (prev_stalled) check("stall_hold", 64'({bus.out_valid, obs}), 64'({1'b1, prev_obs}));
        if (level_done && en) ld_count++;
        if (done && en) begin
            frames++;
            done_cyc = cyc;
        end
        case (mode)
            0:       begin gv = DATA_W'(p);      fv = DATA_W'(-p);       end
            1:       begin gv = DATA_W'($urandom); fv = DATA_W'($urandom); end
            default: begin gv = 16'h1234;        fv = DATA_W'($urandom); end
        endcase
        start = st; bus.out_ready = rdy; bus.in_valid = vld; clk_enable = en;
        bus.g_in = gv; bus.f_in = fv;
        out_fire  = bus.out_valid && rdy && en;
        in_fire   = bus.in_ready && vld && en;
        start_acc = st && en && !model_busy;
        ld_new = 0; fin_new = 0;
        if (out_fire) begin
            check("slot_expected", 64'(expq.size() != 0), 64'(1));
            slots++;
            if (expq.size() != 0) begin
                e = expq.pop_front();
                check("slot", 64'(obs), 64'(e.bits));
                ld_new  = e.bits[0];
                fin_new = e.fin;
            end
        end
        if (in_fire) begin
            lvl = level_of(p);
            e_even.bits = {gv, fv, 1'b0, LVL_W'(lvl), 1'b0};
            e_even.fin  = 1'b0;
`ifdef UPSAMPLE_HOLD_EN
            e_odd.bits  = {gv, fv, 1'b1, LVL_W'(lvl), last_of(p)};
`else
            e_odd.bits  = {DATA_W'(0), DATA_W'(0), 1'b1, LVL_W'(lvl), last_of(p)};
`endif
            e_odd.fin   = (p == frame_pairs() - 1);
            expq.push_back(e_even);
            expq.push_back(e_odd);
            $display("pair %0d level %0d g=%h f=%h cycle %0d", p, lvl, gv, fv, cyc);
            p++;
        end
        if (en) begin
            if (start_acc) begin
                model_busy = 1;
                p = 0;
                start_cyc = cyc;
            end
            if (exp_ld && ld_fin) model_busy = 0;
            exp_done = exp_ld && ld_fin;
            exp_ld   = ld_new;
            ld_fin   = fin_new;
        end
        prev_stalled = bus.out_valid && !(rdy && en);
        prev_obs     = obs;
    endtask

    task automatic run_until_done(input int rdy_pct, input int vld_pct, input int st_pct,
                                  input int max_cyc);
        int f0 = frames;
        for (int i = 0; i < max_cyc && frames == f0; i++) begin
            cycle(model_busy && ($urandom_range(99) < st_pct),
                  $urandom_range(99) < rdy_pct, $urandom_range(99) < vld_pct, 1'b1);
        end
        check("frame_completes", 64'(frames), 64'(f0 + 1));
    endtask

    initial begin
        logic [SLOT_W+5:0] snap;
        bit found;
        bus.in_valid = 0; bus.out_ready = 0; bus.g_in = '0; bus.f_in = '0;

        // power-on reset
        repeat (2) @(negedge clk);
        check_reset_outputs("init");
        reset = 0;

        // frame A: full rate, g=n f=-n
        mode = 0; slots = 0; ld_count = 0;
        cycle(1, 1, 1, 1);
        run_until_done(100, 100, 0, 2000);
        check("latency_done", 64'(done_cyc - start_cyc), 64'(722));
        check("slots_frameA", 64'(slots), 64'(480));
        check("level_done_count", 64'(ld_count), 64'(LEVELS));

        // frame B: FETCH starvation, clock-enable freeze, random handshakes
        mode = 1; slots = 0;
        cycle(1, 1, 0, 1);
        for (int i = 0; i < 10; i++) begin
            cycle(0, 1, 0, 1);
            check("fetch_wait_in_ready", 64'(bus.in_ready), 64'(1));
            check("fetch_wait_out_valid", 64'(bus.out_valid), 64'(0));
        end
        cycle(0, 0, 1, 1);
        cycle(0, 1, 1, 0);
        check("freeze_in_even", 64'({bus.out_valid, bus.out_phase}), 64'(2'b10));
        snap = {bus.in_ready, bus.out_valid, bus.g_out, bus.f_out, bus.out_phase,
                bus.out_level, bus.out_last, level_done, busy, done};
        for (int i = 0; i < 4; i++) begin
            cycle(0, 1, 1, 0);
            check("freeze_outputs", 64'({bus.in_ready, bus.out_valid, bus.g_out, bus.f_out,
                  bus.out_phase, bus.out_level, bus.out_last, level_done, busy, done}),
                  64'(snap));
        end
        run_until_done(50, 70, 5, 6000);
        check("slots_frameB", 64'(slots), 64'(480));

        // idle afterwards: stray starts during the frame must not have queued one
        repeat (5) cycle(0, 1, 1, 1);
        check("idle_busy", 64'(busy), 64'(0));
        check("frame_count", 64'(frames), 64'(2));

        // frame C: async reset during a level-2 odd slot
        mode = 2; slots = 0; found = 0;
        cycle(1, 1, 1, 1);
        for (int i = 0; i < 3000 && !found; i++) begin
            cycle(0, $urandom_range(99) < 60, 1, 1);
            found = bus.out_valid && bus.out_phase && (bus.out_level == 2);
        end
        check("reach_level2_odd", 64'(found), 64'(1));
        #2 reset = 1;
        #1 check_reset_outputs("midframe");
        model_clear();
        @(negedge clk);
        start = 0;
        reset = 0;

        // frame D: restart from level 0 after reset, constant g
        slots = 0;
        cycle(1, 1, 1, 1);
        run_until_done(70, 80, 5, 6000);
        check("slots_frameD", 64'(slots), 64'(480));
        check("frame_count_end", 64'(frames), 64'(3));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passed, total);
        $fatal(1, "watchdog expired");
    end
endmodule
